// File: rtl/rs_hs_pkg.sv
// rs_hs_pkg: shared constants and helpers for the relay-station handshake
// pipeline (grace-period derivation, tail-FIFO depth margin, occupancy type).
package rs_hs_pkg;

    // Spare entries kept on top of grace + user depth so the registered
    // ready threshold never lands exactly on the full boundary.
    localparam int RS_HS_DEPTH_MARGIN = 4;

    // Words that can still arrive after the tail drops ready: every body
    // level holds two words, and the ready/valid head registers plus any
    // extra stages in front of the tail each add one.
    function automatic int rs_hs_grace_period(input int body_level,
                                              input int ready_in_head,
                                              input int valid_in_head,
                                              input int extra_before_tail);
        return body_level * 2 + ready_in_head + valid_in_head + extra_before_tail;
    endfunction

    // Occupancy has to represent 0..REAL_DEPTH inclusive, hence one extra bit.
    function automatic int rs_hs_occ_width(input int real_depth);
        return $clog2(real_depth) + 1;
    endfunction

    localparam int RS_HS_DEFAULT_REAL_DEPTH =
        rs_hs_grace_period(5, 1, 1, 1) + 24 + RS_HS_DEPTH_MARGIN;

    typedef logic [rs_hs_occ_width(RS_HS_DEFAULT_REAL_DEPTH)-1:0] rs_hs_occ_t;

endpackage

// File: rtl/rs_hs_tail_mem.sv
// rs_hs_tail_mem: REAL_DEPTH x DATA_WIDTH storage for the tail FIFO.
// Ports: clk; i_we/i_waddr/i_wdata synchronous write; i_raddr/o_rdata
// asynchronous read (distributed-RAM style). No reset on the array.
module rs_hs_tail_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int REAL_DEPTH = 41,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [REAL_DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/rs_hs_pipeline_tail_fifo.sv
// rs_hs_pipeline_tail_fifo: tail stage of the relay-station handshake
// pipeline. Absorbs up to GRACE_PERIOD in-flight words after in_ready drops
// and presents a first-word-fall-through valid/ready interface downstream.
// Ports: clk, reset (sync, active-high); in_valid/in_data from the last body
// level, in_ready (registered) back to it; out_valid/out_data/out_ready to
// the consumer; overflow (sticky drop flag); occupancy (current count).
// Optional feature macro: RS_HS_TAIL_OVERFLOW_CHECK_EN enables the sticky
// overflow register and a simulation assertion on dropped writes; without
// it overflow is tied low (drops still happen silently).
module rs_hs_pipeline_tail_fifo
    import rs_hs_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH           = 24,
    parameter int GRACE_PERIOD    = rs_hs_grace_period(5, 1, 1, 1),
    parameter int REAL_DEPTH      = GRACE_PERIOD + DEPTH + RS_HS_DEPTH_MARGIN,
    parameter int REAL_ADDR_WIDTH = $clog2(REAL_DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_WIDTH-1:0]      out_data,
    input  logic                       out_ready,
    output logic                       overflow,
    output logic [REAL_ADDR_WIDTH:0]   occupancy
);

    localparam int OCC_W = REAL_ADDR_WIDTH + 1;
    localparam logic [OCC_W-1:0]           L_FULL    = OCC_W'(REAL_DEPTH);
    localparam logic [OCC_W-1:0]           L_RDY_TH  = OCC_W'(REAL_DEPTH - GRACE_PERIOD - 2);
    localparam logic [REAL_ADDR_WIDTH-1:0] L_LAST    = REAL_ADDR_WIDTH'(REAL_DEPTH - 1);

    logic [REAL_ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
    logic [OCC_W-1:0]           r_count;
    logic                       r_in_ready;

    logic                       w_full, w_rd, w_wr;
    logic [OCC_W-1:0]           w_count_next;

    assign out_valid = (r_count != '0);
    assign w_full    = (r_count == L_FULL);
    assign w_rd      = out_valid & out_ready;
    // A read in the same cycle frees the head slot, so a full FIFO still
    // accepts; the write lands on the entry being vacated.
    assign w_wr      = in_valid & (~w_full | w_rd);

    assign w_count_next = r_count + OCC_W'(w_wr) - OCC_W'(w_rd);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b0;
        end else begin
            // Depth is not a power of two: wrap explicitly at the last entry.
            if (w_wr) r_wr_ptr <= (r_wr_ptr == L_LAST) ? '0 : r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= (r_rd_ptr == L_LAST) ? '0 : r_rd_ptr + 1'b1;
            r_count    <= w_count_next;
            // Ready is fed from count_next so a drain is visible upstream one
            // cycle earlier than if it were derived from r_count.
            r_in_ready <= (w_count_next <= L_RDY_TH);
        end
    end

    rs_hs_tail_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .REAL_DEPTH (REAL_DEPTH),
        .ADDR_WIDTH (REAL_ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr & ~reset),
        .i_waddr (r_wr_ptr),
        .i_wdata (in_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (out_data)
    );

    assign in_ready  = r_in_ready;
    assign occupancy = r_count;

`ifdef RS_HS_TAIL_OVERFLOW_CHECK_EN
    logic w_drop;
    logic r_overflow;

    assign w_drop = in_valid & w_full & ~w_rd;

    always_ff @(posedge clk) begin
        if (reset)       r_overflow <= 1'b0;
        else if (w_drop) r_overflow <= 1'b1;
    end

    assign overflow = r_overflow;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!w_drop)
                else $error("rs_hs_pipeline_tail_fifo: word dropped while full");
        end
    end
`endif
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: doc/rs_hs_pipeline_tail_fifo.md
# rs_hs_pipeline_tail_fifo

Tail stage of the relay-station handshake pipeline. It sits directly downstream of the last body register level and consumes what that level produces. Because the ready path upstream is pipelined, the body may keep delivering up to GRACE_PERIOD words after ready drops. This block absorbs every in-flight word in a FIFO of REAL_DEPTH entries, drives the registered ready back into the body chain, and presents a first-word-fall-through valid/ready/data interface to the consumer.

## Interface
Parameters:
- DATA_WIDTH, 32: payload width.
- DEPTH, 24: user-visible buffering depth.
- GRACE_PERIOD, 13: maximum words in flight after in_ready deasserts (BODY_LEVEL*2 + head pipeline stages).
- REAL_DEPTH, GRACE_PERIOD+DEPTH+4: physical entries (41 by default).
- REAL_ADDR_WIDTH, $clog2(REAL_DEPTH): pointer width.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  word from the last body level.
- in_data  in  DATA_WIDTH  payload.
- in_ready  out  1  registered ready to the body chain (pipelined upstream).
- out_valid  out  1  FIFO non-empty.
- out_data  out  DATA_WIDTH  head-of-FIFO word.
- out_ready  in  1  consumer accept.
- overflow  out  1  sticky: a word arrived while full.
- occupancy  out  REAL_ADDR_WIDTH+1  current count.

## Operation
- Write: in_valid=1 and count<REAL_DEPTH → store at wr_ptr, advance wr_ptr. in_valid is not qualified by in_ready; upstream is allowed to send during the grace window.
- Read: out_valid=1 and out_ready=1 → advance rd_ptr.
- Pointer wrap: explicit, REAL_DEPTH-1 → 0. REAL_DEPTH is not a power of two, so modulo-2^n wrap is forbidden.
- count_next = count + write − read. A simultaneous write and read leaves count unchanged, including when full. When empty, a read cannot occur (out_valid=0), so the write alone lands.
- in_ready register is loaded with (count_next <= REAL_DEPTH − GRACE_PERIOD − 2): 26 by default.
- Full with in_valid=1 and no read in the same cycle: the word is dropped, pointers and count are unchanged, and the overflow handling under Configuration applies.
- out_data = mem[rd_ptr], read combinationally; it holds stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: in_ready=0, out_valid=0, occupancy=0, overflow=0, out_data don't-care, pointers=0. In the cycle after reset deasserts, in_ready=1.
- Write in cycle N → out_valid=1 in cycle N+1 (1-cycle latency).
- Read in cycle N → count decrements at N+1. in_ready reflects it at N+1, because it is loaded from count_next.
- Reset asserted mid-stream: all state clears next edge and stored words are discarded. in_valid is ignored while reset=1.

## Configuration
- RS_HS_TAIL_OVERFLOW_CHECK_EN defined:
  - overflow is a sticky register, set on a dropped write and cleared only by reset.
  - A simulation-only immediate assertion fires on the drop.
- Not defined:
  - overflow is tied to 0 and the write is still dropped.
  - No assertion logic is generated.

## Structure
- Shared package rs_hs_pkg:
  - function rs_hs_grace_period(body_level, ready_in_head, valid_in_head, extra_before_tail).
  - localparam RS_HS_DEPTH_MARGIN = 4.
  - typedef for occupancy width derivation.
- One sub-module, rs_hs_tail_mem: a REAL_DEPTH×DATA_WIDTH storage array with a synchronous write port and an asynchronous read port. It is inferable as distributed RAM.

## Test plan
- Reset, then one word 0xDEADBEEF at cycle 5 with out_ready=1 → out_valid=1 at cycle 6, out_data=0xDEADBEEF, then out_valid=0 at cycle 7, occupancy back to 0.
- Stream 27 words back-to-back with out_ready=0 → in_ready=0 the cycle after the 27th write. Continue 13 more grace words → all stored, occupancy=40, overflow=0.
- Continue to 41 words, then send a 42nd with out_ready=0 → word dropped, occupancy stays 41. overflow=1 with the macro, 0 without it. Drain → 41 words in order, values 0..40.
- Full FIFO with in_valid=1 and out_ready=1 for 10 cycles → occupancy stays 41, no drop, order preserved across the pointer wrap at entry 40→0.
- Random valid/ready at 50%/50% for 10k words → output sequence equals input sequence, and in_ready=0 whenever the prior count_next exceeded 26.
- Assert reset at occupancy 17 → next cycle out_valid=0, occupancy=0, in_ready=0. The next cycle in_ready=1, and old data never reappears.
